// File: rtl/log_calc.sv
// floor/ceil(log_b(n)) by repeated multiply; result after ceil+2 edges (1 if illegal), held until out_ready.
// Define LOG_CALC_SIZE_EN to add the out_bit_size / out_enc_size outputs.
module log_calc #(
  parameter int WIDTH = 32,
  parameter int LOG_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG_W-1:0] out_floor,
  output logic [LOG_W-1:0] out_ceil,
  output logic             out_err
`ifdef LOG_CALC_SIZE_EN
  ,
  output logic [LOG_W:0]   out_bit_size,
  output logic [LOG_W:0]   out_enc_size
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [WIDTH-1:0]       r_n, r_b;
  logic [2*WIDTH-1:0]     r_p;
  logic [LOG_W-1:0]       r_k;
  logic [LOG_W-1:0]       r_floor, r_ceil;
  logic                   r_err;
  logic                   w_accept, w_finish, w_illegal, w_lt;
  logic [2*WIDTH-1:0]     w_prod, w_n_ext;
  logic [LOG_W-1:0]       w_floor;

  assign w_illegal = (in_n == '0) || (in_b < WIDTH'(2));
  assign w_n_ext   = {{WIDTH{1'b0}}, r_n};
  assign w_lt      = (r_p < w_n_ext);
  // p < n < 2^WIDTH whenever we multiply, so the low half of p carries the full value
  assign w_prod    = {{WIDTH{1'b0}}, r_p[WIDTH-1:0]} * {{WIDTH{1'b0}}, r_b};
  assign w_floor   = (r_p == w_n_ext) ? r_k : r_k - LOG_W'(1);

  assign out_floor = r_floor;
  assign out_ceil  = r_ceil;
  assign out_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_illegal ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!w_lt) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_k     <= '0;
      r_floor <= '0;
      r_ceil  <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_n     <= in_n;
      r_b     <= in_b;
      r_k     <= '0;
      r_floor <= '0;
      r_ceil  <= '0;
      r_err   <= w_illegal;
      r_p     <= w_illegal ? '0 : {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else if (r_state == S_RUN) begin
      if (w_lt) begin
        r_p <= w_prod;
        if (r_k != LOG_W'(WIDTH)) r_k <= r_k + LOG_W'(1);
      end else begin
        r_ceil  <= r_k;
        r_floor <= w_floor;
      end
    end
  end

`ifdef LOG_CALC_SIZE_EN
  logic [LOG_W:0] r_bit_size, r_enc_size;

  assign out_bit_size = r_bit_size;
  assign out_enc_size = r_enc_size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_size <= '0;
      r_enc_size <= '0;
    end else if (w_accept) begin
      r_bit_size <= (LOG_W+1)'(1);
      r_enc_size <= (LOG_W+1)'(1);
    end else if (w_finish) begin
      r_bit_size <= {1'b0, w_floor} + (LOG_W+1)'(1);
      r_enc_size <= (r_n == WIDTH'(1)) ? (LOG_W+1)'(1) : {1'b0, r_k};
    end
  end
`endif

endmodule

// File: tb/tb_log_calc.sv
// Bench for log_calc: directed vector table, held-output and mid-run reset sequences, random ops vs a model.
module tb_log_calc;
  localparam int W  = 32;
  localparam int LW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [W-1:0]  in_n, in_b;
  logic [LW-1:0] out_floor, out_ceil;
`ifdef LOG_CALC_SIZE_EN
  logic [LW:0]   out_bit_size, out_enc_size;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  log_calc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_floor(out_floor), .out_ceil(out_ceil), .out_err(out_err)
`ifdef LOG_CALC_SIZE_EN
    , .out_bit_size(out_bit_size), .out_enc_size(out_enc_size)
`endif
  );

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] b;
    int           hold;
    int           fl;
    int           ce;
    int           er;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: floor is the largest k with b^k <= n; ceil rounds up unless n is an exact power.
  task automatic model(input longint unsigned n, input longint unsigned b,
                       output int fl, output int ce, output int er, output int lat);
    longint unsigned pw;
    if (n == 0 || b < 2) begin
      er = 1; fl = 0; ce = 0; lat = 1;
    end else begin
      er = 0; fl = 0; pw = 1;
      while (pw * b <= n) begin
        pw = pw * b;
        fl++;
      end
      ce  = (pw == n) ? fl : fl + 1;
      lat = ce + 2;
    end
  endtask

  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] b, input int hold,
                        input int fl, input int ce, input int er, input int lat, input string tag);
    int cyc;
    logic [LW-1:0] fl_cap, ce_cap;
    @(negedge clk);
    chk({tag, " ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_n = n; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_n = $urandom; in_b = $urandom;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " floor"}, out_floor, fl);
    chk({tag, " ceil"}, out_ceil, ce);
    chk({tag, " err"}, out_err, er);
    chk({tag, " ready_busy"}, in_ready, 0);
`ifdef LOG_CALC_SIZE_EN
    chk({tag, " bit_size"}, out_bit_size, er ? 1 : fl + 1);
    chk({tag, " enc_size"}, out_enc_size, er ? 1 : ((n == 1) ? 1 : ce));
`endif
    fl_cap = out_floor; ce_cap = out_ceil;
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_ready"}, in_ready, 0);
      chk({tag, " hold_out"}, {out_floor, out_ceil}, {fl_cap, ce_cap});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drop_valid"}, out_valid, 0);
    chk({tag, " back_idle"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int fl, ce, er, lat;
    logic [W-1:0] rn, rb;

    vecs[0] = '{n: 32'd1000,       b: 32'd10, hold: 0,  fl: 3,  ce: 3,  er: 0, lat: 5};
    vecs[1] = '{n: 32'd1001,       b: 32'd10, hold: 1,  fl: 3,  ce: 4,  er: 0, lat: 6};
    vecs[2] = '{n: 32'd1,          b: 32'd7,  hold: 0,  fl: 0,  ce: 0,  er: 0, lat: 2};
    vecs[3] = '{n: 32'hFFFF_FFFF,  b: 32'd2,  hold: 0,  fl: 31, ce: 32, er: 0, lat: 34};
    vecs[4] = '{n: 32'd0,          b: 32'd5,  hold: 2,  fl: 0,  ce: 0,  er: 1, lat: 1};
    vecs[5] = '{n: 32'd9,          b: 32'd1,  hold: 2,  fl: 0,  ce: 0,  er: 1, lat: 1};
    vecs[6] = '{n: 32'd100,        b: 32'd3,  hold: 10, fl: 4,  ce: 5,  er: 0, lat: 7};
    vecs[7] = '{n: 32'd5,          b: 32'd9,  hold: 0,  fl: 0,  ce: 1,  er: 0, lat: 3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_n = '0; in_b = '0;
    #1;
    chk("reset valid", out_valid, 0);
    chk("reset ready", in_ready, 1);
    chk("reset floor", out_floor, 0);
    chk("reset ceil", out_ceil, 0);
    chk("reset err", out_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].n, vecs[i].b, vecs[i].hold, vecs[i].fl, vecs[i].ce, vecs[i].er,
             vecs[i].lat, $sformatf("vec%0d", i));

    // Reset mid-RUN discards the pending computation.
    @(negedge clk);
    in_valid = 1'b1; in_n = 32'd1_000_000; in_b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst valid", out_valid, 0);
    chk("midrst ready", in_ready, 1);
    chk("midrst floor", out_floor, 0);
    chk("midrst ceil", out_ceil, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd8, 32'd2, 0, 3, 3, 0, 5, "post_rst");

    // Reset while DONE holds a result.
    @(negedge clk);
    in_valid = 1'b1; in_n = 32'd50; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("done_rst pre valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("done_rst valid", out_valid, 0);
    chk("done_rst ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rn = $urandom;
        1: rn = $urandom_range(0, 5000);
        2: rn = $urandom_range(0, 3);
        default: rn = 32'hFFFF_FFFF - $urandom_range(0, 8);
      endcase
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 40);
        1: rb = 32'd2;
        2: rb = $urandom;
        default: rb = $urandom_range(2, 2000);
      endcase
      model(rn, rb, fl, ce, er, lat);
      run_op(rn, rb, $urandom_range(0, 3), fl, ce, er, lat, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/log_calc.md
Name: log_calc

Overview:
- Run-time hardware counterpart of the team's elaboration-time sizing functions.
- Accepts an operand n and a base b over a valid/ready handshake, then computes floor(log_b(n)) and ceil(log_b(n)) by iterative multiplication.
- Returns the result over a second valid/ready handshake.
- Used by configurable datapaths whose widths or depths are only known at run time, for example from programmable register fields.

Parameters:
- WIDTH, 32: width of n and b; must be >= 2.
- LOG_W, $clog2(WIDTH+1): width of the log outputs; holds values up to WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block idle, operand can be accepted.
- in_n  in  WIDTH  operand n, unsigned.
- in_b  in  WIDTH  base b, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_floor  out  LOG_W  floor(log_b(n)).
- out_ceil  out  LOG_W  ceil(log_b(n)).
- out_err  out  1  illegal operands (n == 0 or b < 2).

Behaviour:
- Interface fixed: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - Internal: state IDLE; power p = 0, counter k = 0.
  - Outputs: out_valid = 0, out_floor = 0, out_ceil = 0, out_err = 0.
  - in_ready = 1, since it is decoded from state IDLE.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch n and b.
    - Illegal operands (n == 0 or b < 2): go to DONE with err = 1, floor = ceil = 0.
    - Otherwise: set p = 1, k = 0, go to RUN.
  - RUN: in_ready = 0. Each cycle:
    - If p < n: p <= p*b, k <= k+1.
    - Else: ceil <= k; floor <= (p == n) ? k : k-1; go to DONE.
  - DONE: out_valid = 1; outputs held stable.
    - On out_ready: go to IDLE; out_valid drops on the next edge.
- Latency, counted in edges from the accepting edge to out_valid visible:
  - Legal operands: ceil + 2.
  - Illegal operands: 1.
- Arithmetic:
  - The product p*b is computed at 2*WIDTH bits, so it never wraps.
  - p is kept at 2*WIDTH bits. Because p < n < 2^WIDTH before each multiply, the product is bounded.
  - The comparison is done at 2*WIDTH bits.
  - k saturates logically at WIDTH and never exceeds it for legal inputs.
- Boundary cases:
  - n = 1: floor = ceil = 0, latency 2.
  - b > n: ceil = 1, floor = 0.
  - n = 2^WIDTH - 1, b = 2: ceil = WIDTH, floor = WIDTH - 1.
- Handshake rules:
  - in_ready and out_valid are never high together.
  - A new operand is accepted only from IDLE, so back-to-back operation costs one IDLE cycle.
  - in_n and in_b are don't-care outside the accepting cycle.
  - out_* may change only on leaving DONE.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE with reset values; the pending result is discarded.

Optional Feature:
- Macro: LOG_CALC_SIZE_EN.
- Defined: adds two outputs, each LOG_W+1 bits wide, registered together with out_floor and out_ceil.
  - out_bit_size = floor + 1 for legal n; 1 when err.
  - out_enc_size = (n == 1) ? 1 : ceil; 1 when err.
  - Both are meaningful as bit and encoding sizes when b = 2.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- n=1000, b=10 -> floor=3, ceil=3, err=0, out_valid 5 edges after accept.
- n=1001, b=10 -> floor=3, ceil=4, latency 6; n=1, b=7 -> floor=0, ceil=0, latency 2.
- n=32'hFFFF_FFFF, b=2 -> floor=31, ceil=32, no overflow, latency 34. With LOG_CALC_SIZE_EN: bit_size=32, enc_size=32.
- n=0, b=5 and n=9, b=1 -> err=1, floor=ceil=0, latency 1; in_ready low until consumed.
- n=100, b=3 with out_ready held low 10 cycles -> floor=4, ceil=5 held stable with out_valid=1 and in_ready=0; release -> IDLE next edge.
- Assert rst_n low during RUN with n=1_000_000, b=2 -> out_valid=0, in_ready=1 immediately. Next request n=8, b=2 -> floor=ceil=3.
